// File: rtl/oled_spi_pkg.sv
// Shared types and constants for the OLED SPI byte transmitter.
// Holds the FSM state encoding and the frame geometry constants.
package oled_spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } spi_state_t;

    localparam int BITS_PER_BYTE          = 8;
    localparam int HALF_PERIODS_PER_FRAME = 18;

endpackage

// File: rtl/spi_tick_gen.sv
// Half-period tick generator: counts 0..CLK_DIV-1, Tick on the last count.
// Ports: Clock, Reset (sync, high), Clear (restart count), Tick (out).
module spi_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Clear,
    output logic Tick
);

    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_q;

    assign Tick = (cnt_q == LAST);

    always_ff @(posedge Clock) begin
        if (Reset || Clear) begin
            cnt_q <= '0;
        end else if (Tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/oled_spi_tx.sv
// SPI mode-0 write-only byte transmitter for the OLED pads, MSB first.
// Ports: Tx* byte handshake in, Busy out, nCS/DnC/SDIN/SCLK registered pads.
module oled_spi_tx
    import oled_spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic [7:0] TxData,
    input  logic       TxDnC,
    input  logic       TxValid,
    output logic       TxReady,
    output logic       Busy,
    output logic       nCS,
    output logic       DnC,
    output logic       SDIN,
    output logic       SCLK
);

    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

    spi_state_t state_q;
    logic [7:0] shift_q;
    logic [2:0] bit_q;
    logic       ncs_q;
    logic       dnc_q;
    logic       sdin_q;
    logic       sclk_q;
    logic       tick;
    logic       accept;

    assign TxReady = !Reset &&
                     ((state_q == IDLE) || ((state_q == HOLD) && tick));
    assign accept  = TxValid && TxReady;
    assign Busy    = (state_q != IDLE);
    assign nCS     = ncs_q;
    assign DnC     = dnc_q;
    assign SDIN    = sdin_q;
    assign SCLK    = sclk_q;

    // Accept is the only way into SETUP, so it doubles as the divider clear.
    spi_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .Clock(Clock),
        .Reset(Reset),
        .Clear(accept),
        .Tick (tick)
    );

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            shift_q <= '0;
            bit_q   <= '0;
            ncs_q   <= 1'b1;
            dnc_q   <= 1'b0;
            sdin_q  <= 1'b0;
            sclk_q  <= 1'b0;
        end else if (accept) begin
            state_q <= SETUP;
            shift_q <= TxData;
            bit_q   <= '0;
            ncs_q   <= 1'b0;
            dnc_q   <= TxDnC;
            sdin_q  <= TxData[7];
        end else begin
            unique case (state_q)
                IDLE: begin
                    ncs_q  <= 1'b1;
                    sclk_q <= 1'b0;
                end
                SETUP: begin
                    if (tick) begin
                        state_q <= SHIFT;
                        sclk_q  <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (sclk_q) begin
                            // Falling edge: bit counter wraps to 0 after bit0,
                            // and SDIN keeps bit0 for the final low phase.
                            sclk_q <= 1'b0;
                            bit_q  <= bit_q + 1'b1;
                            if (bit_q != LAST_BIT) begin
                                shift_q <= {shift_q[6:0], 1'b0};
                                sdin_q  <= shift_q[6];
                            end
                        end else if (bit_q == '0) begin
                            // Low phase after the 8th fall ends the byte.
                            state_q <= HOLD;
                        end else begin
                            sclk_q <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        state_q <= IDLE;
                        ncs_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_oled_spi_tx.sv
// Directed self-checking bench for oled_spi_tx (CLK_DIV = 2 and 1).
// Ports: none; drives two DUT instances from one clock.
module tb_oled_spi_tx;
    import oled_spi_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst2, v2, c2, rdy2, busy2, ncs2, dco2, sdin2, sclk2;
    logic [7:0] d2;
    logic       rst1, v1, c1, rdy1, busy1, ncs1, dco1, sdin1, sclk1;
    logic [7:0] d1;

    oled_spi_tx #(.CLK_DIV(2)) dut2 (
        .Clock(clk), .Reset(rst2), .TxData(d2), .TxDnC(c2),
        .TxValid(v2), .TxReady(rdy2), .Busy(busy2), .nCS(ncs2),
        .DnC(dco2), .SDIN(sdin2), .SCLK(sclk2)
    );

    oled_spi_tx #(.CLK_DIV(1)) dut1 (
        .Clock(clk), .Reset(rst1), .TxData(d1), .TxDnC(c1),
        .TxValid(v1), .TxReady(rdy1), .Busy(busy1), .nCS(ncs1),
        .DnC(dco1), .SDIN(sdin1), .SCLK(sclk1)
    );

    int total = 0;
    int bad   = 0;

    logic [7:0] txb [4];
    logic       txd [4];
    int         ntx;

    int m_bits, m_dncb, m_nb, m_low, m_maxrun, m_busy;
    int m_rdy, m_acc, m_dnc1, m_first, m_last;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s1, input logic v,
                         input logic [7:0] d, input logic dc);
        if (s1) begin
            v1 = v; d1 = d; c1 = dc;
        end else begin
            v2 = v; d2 = d; c2 = dc;
        end
    endtask

    // Sends txb[0..ntx-1] with TxValid held, watching for ncyc cycles.
    task automatic mon(input bit s1, input int ncyc, input int pulse_at);
        int   idx;
        int   run;
        bit   pend;
        logic pscl, ncs, scl, sd, dc, bz, rd;
        idx = 0; run = 0; pscl = 1'b0;
        m_bits = 0; m_dncb = 0; m_nb = 0; m_low = 0; m_maxrun = 0;
        m_busy = 0; m_rdy = 0; m_acc = 0; m_dnc1 = 0;
        m_first = 0; m_last = 0;
        drive(s1, 1'b1, txb[0], txd[0]);
        pend = s1 ? rdy1 : rdy2;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            if (pend) begin
                m_acc++;
                idx++;
                if (idx < ntx) drive(s1, 1'b1, txb[idx], txd[idx]);
                else drive(s1, 1'b0, 8'h00, 1'b0);
            end
            ncs = s1 ? ncs1  : ncs2;
            scl = s1 ? sclk1 : sclk2;
            sd  = s1 ? sdin1 : sdin2;
            dc  = s1 ? dco1  : dco2;
            bz  = s1 ? busy1 : busy2;
            rd  = s1 ? rdy1  : rdy2;
            if (!ncs) begin
                m_low++;
                run++;
                if (dc) m_dnc1++;
                if (rd) m_rdy++;
            end else begin
                run = 0;
            end
            if (run > m_maxrun) m_maxrun = run;
            if (bz) m_busy++;
            if (!pscl && scl) begin
                m_bits = (m_bits << 1) | int'(sd);
                m_dncb = (m_dncb << 1) | int'(dc);
                if (m_nb == 0) m_first = i;
                m_last = i;
                m_nb++;
            end
            pscl = scl;
            if (i == pulse_at) drive(s1, 1'b1, 8'h55, txd[0]);
            else if (i == pulse_at + 1) drive(s1, 1'b0, 8'h00, 1'b0);
            pend = (s1 ? v1 : v2) && rd;
        end
    endtask

    initial begin
        int   rises;
        logic pscl;
        rst2 = 1'b1; rst1 = 1'b1;
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        drive(1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_ncs",   int'(ncs2),  1);
        chk("rst_sclk",  int'(sclk2), 0);
        chk("rst_sdin",  int'(sdin2), 0);
        chk("rst_dnc",   int'(dco2),  0);
        chk("rst_busy",  int'(busy2), 0);
        chk("rst_rdy",   int'(rdy2),  0);
        chk("rst_ncs1",  int'(ncs1),  1);
        chk("rst_rdy1",  int'(rdy1),  0);
        rst2 = 1'b0; rst1 = 1'b0;
        @(negedge clk);
        chk("idle_rdy",  int'(rdy2),  1);

        txb[0] = 8'hA5; txd[0] = 1'b0; ntx = 1;
        mon(1'b0, 50, -5);
        chk("t1_bits",  m_bits, 'hA5);
        chk("t1_nb",    m_nb,   8);
        chk("t1_dnc",   m_dncb, 0);
        chk("t1_low",   m_low,  HALF_PERIODS_PER_FRAME * 2);
        chk("t1_busy",  m_busy, 36);
        chk("t1_rdy",   m_rdy,  1);
        chk("t1_acc",   m_acc,  1);
        chk("t1_span",  m_last - m_first, 28);
        chk("t1_endcs", int'(ncs2), 1);

        txb[0] = 8'h3C; txd[0] = 1'b1;
        txb[1] = 8'hFF; txd[1] = 1'b1; ntx = 2;
        mon(1'b0, 90, -5);
        chk("t2_bits",  m_bits,   'h3CFF);
        chk("t2_nb",    m_nb,     16);
        chk("t2_dnc",   m_dncb,   'hFFFF);
        chk("t2_run",   m_maxrun, 72);
        chk("t2_acc",   m_acc,    2);
        chk("t2_rdy",   m_rdy,    2);

        txb[0] = 8'h81; txd[0] = 1'b0;
        txb[1] = 8'h7F; txd[1] = 1'b1; ntx = 2;
        mon(1'b0, 90, -5);
        chk("t3_bits",  m_bits,   'h817F);
        chk("t3_dnc",   m_dncb,   'h00FF);
        chk("t3_dnc1",  m_dnc1,   36);
        chk("t3_run",   m_maxrun, 72);

        drive(1'b0, 1'b1, 8'hF0, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 8'h00, 1'b0);
        rises = 0;
        pscl  = sclk2;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!pscl && sclk2) rises++;
            pscl = sclk2;
            if (rises == 3) break;
        end
        chk("t4_rise3", rises, 3);
        rst2 = 1'b1;
        @(negedge clk);
        chk("t4_ncs",  int'(ncs2),  1);
        chk("t4_sclk", int'(sclk2), 0);
        chk("t4_sdin", int'(sdin2), 0);
        chk("t4_busy", int'(busy2), 0);
        chk("t4_rdy",  int'(rdy2),  0);
        rst2 = 1'b0;
        @(negedge clk);
        txb[0] = 8'h96; txd[0] = 1'b1; ntx = 1;
        mon(1'b0, 50, -5);
        chk("t4_bits", m_bits, 'h96);
        chk("t4_nb",   m_nb,   8);
        chk("t4_low",  m_low,  36);

        txb[0] = 8'h01; txd[0] = 1'b1; ntx = 1;
        mon(1'b1, 30, -5);
        chk("t5_bits", m_bits, 'h01);
        chk("t5_nb",   m_nb,   8);
        chk("t5_low",  m_low,  HALF_PERIODS_PER_FRAME);
        chk("t5_span", m_last - m_first, 14);
        chk("t5_acc",  m_acc,  1);

        txb[0] = 8'hAA; txd[0] = 1'b0; ntx = 1;
        mon(1'b0, 50, 10);
        chk("t6_bits", m_bits, 'hAA);
        chk("t6_nb",   m_nb,   8);
        chk("t6_low",  m_low,  36);
        chk("t6_acc",  m_acc,  1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
